// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder slice.
package fa_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/full_adder_if.sv
// Bundles the data-side signals of full_adder so one instance wires a whole adder.
interface full_adder_if
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
);

  logic             en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic [WIDTH-1:0] S_q;
  logic             Cout_q;

  modport master (
    output en, A, B, Cin,
    input  S, Cout, S_q, Cout_q
  );

  modport slave (
    input  en, A, B, Cin,
    output S, Cout, S_q, Cout_q
  );

endinterface

// File: rtl/full_adder_fa_bit.sv
// One-bit full-adder cell; the ripple element of full_adder.
module fa_bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a combinational result and an
// enable-loaded registered copy cleared by an asynchronous active-low reset.
module full_adder
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [WIDTH-1:0] S_q,
  output logic             Cout_q
);

  logic [WIDTH:0] c;
  logic [WIDTH:0] res_d;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_bit u_bit (
      .A    (A[i]),
      .B    (B[i]),
      .Cin  (c[i]),
      .S    (S[i]),
      .Cout (c[i+1])
    );
  end

  assign Cout  = c[WIDTH];
  assign res_d = {Cout, S};

  // Stage boundary: combinational sum -> registered copy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      S_q    <= '0;
      Cout_q <= 1'b0;
    end else if (en) begin
      S_q    <= res_d[WIDTH-1:0];
      Cout_q <= res_d[WIDTH];
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_bad;

  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(8)) if8 ();

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .nrst   (nrst),
    .en     (if1.en),
    .A      (if1.A),
    .B      (if1.B),
    .Cin    (if1.Cin),
    .S      (if1.S),
    .Cout   (if1.Cout),
    .S_q    (if1.S_q),
    .Cout_q (if1.Cout_q)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .nrst   (nrst),
    .en     (if8.en),
    .A      (if8.A),
    .B      (if8.B),
    .Cin    (if8.Cin),
    .S      (if8.S),
    .Cout   (if8.Cout),
    .S_q    (if8.S_q),
    .Cout_q (if8.Cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Truth table rows {A,B,Cin} -> {Cout,S}
  logic [1:0] tt_exp [8];
  logic [2:0] v3;
  logic [8:0] ref9;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    nrst    = 1'b0;
    if1.en  = 1'b0; if1.A = '0; if1.B = '0; if1.Cin = 1'b0;
    if8.en  = 1'b0; if8.A = '0; if8.B = '0; if8.Cin = 1'b0;
    #1;
    check("rst_S_q1",    64'(if1.S_q),    64'd0);
    check("rst_Cout_q1", 64'(if1.Cout_q), 64'd0);
    check("rst_S_q8",    64'(if8.S_q),    64'd0);
    check("rst_Cout_q8", 64'(if8.Cout_q), 64'd0);

    // 1-bit truth table while held in reset so the registers stay idle
    for (int k = 0; k < 8; k++) begin
      v3 = 3'(k);
      if1.A = v3[2]; if1.B = v3[1]; if1.Cin = v3[0];
      #1;
      check($sformatf("tt%0d_S", k),    64'(if1.S),    64'(tt_exp[k][0]));
      check($sformatf("tt%0d_Cout", k), 64'(if1.Cout), 64'(tt_exp[k][1]));
    end

    if8.A = 8'hFF; if8.B = 8'h00; if8.Cin = 1'b1;
    #1;
    check("ripple_S",    64'(if8.S),    64'h00);
    check("ripple_Cout", 64'(if8.Cout), 64'd1);

    if8.A = 8'h5A; if8.B = 8'h25; if8.Cin = 1'b0;
    #1;
    check("nocarry_S",    64'(if8.S),    64'h7F);
    check("nocarry_Cout", 64'(if8.Cout), 64'd0);

    if8.A = 8'hFF; if8.B = 8'hFF; if8.Cin = 1'b1;
    #1;
    check("max_S",    64'(if8.S),    64'hFF);
    check("max_Cout", 64'(if8.Cout), 64'd1);

    for (int k = 0; k < 1000; k++) begin
      if8.A   = 8'($urandom_range(255));
      if8.B   = 8'($urandom_range(255));
      if8.Cin = 1'($urandom_range(1));
      #1;
      ref9 = 9'(if8.A) + 9'(if8.B) + 9'(if8.Cin);
      check($sformatf("rand%0d", k), 64'({if8.Cout, if8.S}), 64'(ref9));
    end

    // Registered path on the 1-bit adder
    @(negedge clk);
    nrst   = 1'b1;
    if1.en = 1'b1; if1.A = 1'b1; if1.B = 1'b1; if1.Cin = 1'b1;
    @(posedge clk); #1;
    check("load_S_q",    64'(if1.S_q),    64'd1);
    check("load_Cout_q", 64'(if1.Cout_q), 64'd1);

    @(negedge clk);
    if1.en = 1'b0; if1.A = 1'b0; if1.B = 1'b0; if1.Cin = 1'b0;
    @(posedge clk); #1;
    check("hold_S_q",    64'(if1.S_q),    64'd1);
    check("hold_Cout_q", 64'(if1.Cout_q), 64'd1);

    // Async reset between edges, with no clock edge in between
    #2;
    nrst  = 1'b0;
    if1.A = 1'b1; if1.B = 1'b0; if1.Cin = 1'b1;
    #1;
    check("arst_S_q",    64'(if1.S_q),    64'd0);
    check("arst_Cout_q", 64'(if1.Cout_q), 64'd0);
    check("arst_S",      64'(if1.S),      64'd0);
    check("arst_Cout",   64'(if1.Cout),   64'd1);

    // Reset has priority over en at a clock edge
    if1.en = 1'b1;
    @(posedge clk); #1;
    check("rst_pri_S_q",    64'(if1.S_q),    64'd0);
    check("rst_pri_Cout_q", 64'(if1.Cout_q), 64'd0);

    // Release takes effect at the next rising edge
    @(negedge clk);
    nrst  = 1'b1;
    if1.A = 1'b1; if1.B = 1'b0; if1.Cin = 1'b0;
    #1;
    check("rel_pre_S_q", 64'(if1.S_q), 64'd0);
    @(posedge clk); #1;
    check("rel_S_q",    64'(if1.S_q),    64'd1);
    check("rel_Cout_q", 64'(if1.Cout_q), 64'd0);

    // 8-bit registered load
    @(negedge clk);
    if8.en = 1'b1; if8.A = 8'hC8; if8.B = 8'h64; if8.Cin = 1'b1;
    @(posedge clk); #1;
    check("load8_S_q",    64'(if8.S_q),    64'h2D);
    check("load8_Cout_q", 64'(if8.Cout_q), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Combinational full adder, parameterizable to a WIDTH-bit ripple-carry adder. It carries an optional registered copy of the result for pipelined use. The combinational path (S, Cout) is the primary function and is used directly as a leaf arithmetic cell in the fabric datapath. The registered path (S_q, Cout_q) lets it sit between clocked stages without extra glue.

## Interface
Parameters:
- WIDTH, default 1: operand width in bits; legal range 1..64.

Ports:
- clk, input, 1: single system clock; only the registered path uses it.
- nrst, input, 1: reset, asynchronous and active-low; clears the registered path only.
- en, input, 1: load enable for the registered outputs.
- A, input, WIDTH: operand A.
- B, input, WIDTH: operand B.
- Cin, input, 1: carry in.
- S, output, WIDTH: combinational sum, A + B + Cin modulo 2^WIDTH.
- Cout, output, 1: combinational carry out, bit WIDTH of A + B + Cin.
- S_q, output, WIDTH: registered S.
- Cout_q, output, 1: registered Cout.

## Operation
- Per bit i: S[i] = A[i] ^ B[i] ^ c[i]; c[i+1] = (A[i]&B[i]) | (A[i]&c[i]) | (B[i]&c[i]).
- Ripple chain: c[0] = Cin and Cout = c[WIDTH].
- {Cout, S} equals the exact (WIDTH+1)-bit sum A + B + Cin. No overflow flag and no signed interpretation.
- S and Cout are purely combinational. They do not depend on clk, nrst or en, and they must be correct with clk held constant and nrst/en undriven.
- No X/Z handling beyond normal simulator propagation. With all inputs known, outputs are known.
- Registered path:
  - On the clk rising edge with en=1: S_q <= S and Cout_q <= Cout.
  - With en=0: S_q and Cout_q hold their value.
- nrst=0 forces S_q=0 and Cout_q=0 immediately, regardless of clk. This holds mid-operation and has priority over en.
- nrst deassertion takes effect at the next clk rising edge. No synchronizer is inside the block.

## Timing
- Combinational latency is 0 cycles: S and Cout settle within the same time step as an input change. The worst-case path is the WIDTH-stage carry ripple.
- Registered latency is 1 cycle: S_q and Cout_q reflect inputs present at the enabled clk edge.
- Reset values: S_q = 0 and Cout_q = 0. S and Cout have no reset value; they always follow the inputs.
- Simultaneous input change and clock edge: the register captures the pre-edge settled values. Inputs must meet setup to clk.

## Structure
- Sub-module fa_bit: 1-bit cell with ports A, B, Cin, S, Cout implementing the equations above.
  - full_adder instantiates WIDTH copies of fa_bit in a generate loop, chaining Cout to Cin.
- Registered path: one always_ff block with the async reset in its sensitivity list.
- Shared package fa_pkg holds the default-width constant FA_DEFAULT_WIDTH = 1. No typedefs are needed.

## Test plan
- Exhaustive 1-bit truth table, WIDTH=1, clk idle: for all 8 combinations of {A,B,Cin}, wait 1 time unit, then check:
  - 000 -> S=0, Cout=0
  - 001, 010, 100 -> S=1, Cout=0
  - 011, 101, 110 -> S=0, Cout=1
  - 111 -> S=1, Cout=1
- WIDTH=8 carry ripple: A=0xFF, B=0x00, Cin=1 -> S=0x00, Cout=1.
- WIDTH=8 no-carry case: A=0x5A, B=0x25, Cin=0 -> S=0x7F, Cout=0.
- WIDTH=8 randomized: 1000 random {A,B,Cin}; {Cout,S} must equal A+B+Cin in every case.
- Registered path: with en=1, apply A=1, B=1, Cin=1 before a clk edge -> after the edge S_q=1, Cout_q=1.
  - Then drop en and change the inputs -> S_q and Cout_q hold 1, 1.
- Async reset: assert nrst=0 between clock edges while S_q=1 -> S_q=0 and Cout_q=0 immediately, with no clk edge.
  - Combinational S and Cout stay correct during reset.
